enc_bundler: RTL and testbench

Accumulates the per-feature shifted hypervectors produced by the encoder binder stage over one sample and reduces them to a single sparse sample hypervector. Consumes `FEATURES_PER_CC` bound HVs per beat over `NUM_CHUNKS` beats, keeps a per-bit vote counter, then thresholds or sparsifies the counters into the encoded HV. The encoded HV is presented to the downstream classifier/AM stage with a valid/ready handshake.

---
 rtl/hdc_pkg.sv | 21 ++
 rtl/enc_popcount_col.sv | 18 +
 rtl/enc_bundler.sv | 128 ++++++++++++
 tb/tb_enc_bundler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared constants and types for the HDC encoder stages.
package hdc_pkg;

  localparam int HV_DIM          = 1024;
  localparam int FEATURES_PER_CC = 8;
  localparam int NUM_CHUNKS      = 78;
  localparam int SEG_LEN         = 64;

  // Vote counter width: enough to hold one vote per feature of a whole sample.
  function automatic int cnt_w(input int features_per_cc, input int num_chunks);
    return $clog2(features_per_cc * num_chunks + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_REDUCE,
    ST_OUT
  } bundler_state_t;

endpackage

// File: rtl/enc_popcount_col.sv
// Combinational popcount of one HV bit position across the bound HVs of a beat.
module enc_popcount_col #(
  parameter int N = 8
) (
  input  logic [N-1:0]             bits,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int W = $clog2(N + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/enc_bundler.sv
// Per-bit vote accumulation over one sample, reduced to a sparse sample HV.
// Optional: ENC_BUNDLER_SEG_SPARSIFY_EN selects per-segment winner-take-all reduction.
module enc_bundler #(
  parameter int HV_DIM          = hdc_pkg::HV_DIM,
  parameter int FEATURES_PER_CC = hdc_pkg::FEATURES_PER_CC,
  parameter int NUM_CHUNKS      = hdc_pkg::NUM_CHUNKS,
  parameter int THRESHOLD       = 4,
  parameter int SEG_LEN         = hdc_pkg::SEG_LEN
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] shifted_hv [0:FEATURES_PER_CC-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] out_hv,
  output logic              busy
);
  import hdc_pkg::*;

  localparam int CNT_W    = cnt_w(FEATURES_PER_CC, NUM_CHUNKS);
  localparam int PC_W     = $clog2(FEATURES_PER_CC + 1);
  localparam int BEAT_W   = $clog2(NUM_CHUNKS + 1);
  localparam int NUM_SEGS = HV_DIM / SEG_LEN;

  if (HV_DIM % SEG_LEN != 0) begin : g_bad_seg_len
    $error("SEG_LEN must divide HV_DIM");
  end

  bundler_state_t    state, next_state;
  logic [CNT_W-1:0]  cnt     [HV_DIM];
  logic [PC_W-1:0]   col_sum [HV_DIM];
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_idx;
  logic              accept, restart, last_beat, out_done;
  logic [HV_DIM-1:0] reduced_hv;

  for (genvar b = 0; b < HV_DIM; b++) begin : g_col
    logic [FEATURES_PER_CC-1:0] column;
    always_comb begin
      for (int f = 0; f < FEATURES_PER_CC; f++) begin
        column[f] = shifted_hv[f][b];
      end
    end
    enc_popcount_col #(.N(FEATURES_PER_CC)) u_popcount (
      .bits  (column),
      .count (col_sum[b])
    );
  end

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign restart   = start_encoding && (state == ST_ACCUM);
  assign out_done  = out_valid && out_ready;
  // A beat accepted alongside a restart is beat 0 of the new sample.
  assign beat_idx  = restart ? '0 : beat_cnt;
  assign last_beat = accept && (beat_idx == BEAT_W'(NUM_CHUNKS - 1));

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_encoding) next_state = ST_ACCUM;
      ST_ACCUM:  if (last_beat)      next_state = ST_REDUCE;
      ST_REDUCE:                     next_state = ST_OUT;
      ST_OUT:    if (out_ready)      next_state = ST_IDLE;
      default:                       next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      beat_cnt <= '0;
      for (int b = 0; b < HV_DIM; b++) cnt[b] <= '0;
    end else begin
      if (accept)                    beat_cnt <= beat_idx + 1'b1;
      else if (restart || out_done)  beat_cnt <= '0;
      for (int b = 0; b < HV_DIM; b++) begin
        if (accept)                   cnt[b] <= (restart ? '0 : cnt[b]) + CNT_W'(col_sum[b]);
        else if (restart || out_done) cnt[b] <= '0;
      end
    end
  end

`ifdef ENC_BUNDLER_SEG_SPARSIFY_EN
  logic [CNT_W-1:0] best_val;
  int               best_idx;

  // Strict greater-than keeps the lowest index on ties; an all-zero segment stays empty.
  always_comb begin
    reduced_hv = '0;
    best_val   = '0;
    best_idx   = 0;
    for (int s = 0; s < NUM_SEGS; s++) begin
      best_val = '0;
      best_idx = 0;
      for (int i = 0; i < SEG_LEN; i++) begin
        if (cnt[s*SEG_LEN + i] > best_val) begin
          best_val = cnt[s*SEG_LEN + i];
          best_idx = i;
        end
      end
      if (best_val != '0) reduced_hv[s*SEG_LEN + best_idx] = 1'b1;
    end
  end
`else
  always_comb begin
    reduced_hv = '0;
    for (int b = 0; b < HV_DIM; b++) begin
      reduced_hv[b] = (int'(cnt[b]) >= THRESHOLD);
    end
  end
`endif

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst)                    out_hv <= '0;
    else if (state == ST_REDUCE) out_hv <= reduced_hv;
  end

endmodule

// File: tb/tb_enc_bundler.sv
// Directed self-checking bench for enc_bundler (HV_DIM=16, 2 features x 2 beats).
module tb_enc_bundler;

  localparam int HV_DIM = 16;
  localparam int FPC    = 2;
  localparam int NC     = 2;
  localparam int THR    = 2;
  localparam int SEG    = 8;

`ifdef ENC_BUNDLER_SEG_SPARSIFY_EN
  localparam logic [15:0] EXP_BASIC = 16'h0101;
  localparam logic [15:0] EXP_GATE  = 16'h0110;
`else
  localparam logic [15:0] EXP_BASIC = 16'h000F;
  localparam logic [15:0] EXP_GATE  = 16'hFF00;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        start_encoding;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] shifted_hv [0:FPC-1];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_hv;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  enc_bundler #(
    .HV_DIM          (HV_DIM),
    .FEATURES_PER_CC (FPC),
    .NUM_CHUNKS      (NC),
    .THRESHOLD       (THR),
    .SEG_LEN         (SEG)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start_encoding (start_encoding),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .shifted_hv     (shifted_hv),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_hv         (out_hv),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, return 1 time unit after it.
  task automatic applyStimulus(input logic st, input logic vld, input logic [15:0] hv0,
                               input logic [15:0] hv1, input logic ordy);
    start_encoding = st;
    in_valid       = vld;
    shifted_hv[0]  = hv0;
    shifted_hv[1]  = hv1;
    out_ready      = ordy;
    @(posedge clk);
    #1;
    start_encoding = 1'b0;
    in_valid       = 1'b0;
  endtask

  task automatic runSample(input string tag, input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1, input logic [15:0] expected);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, a0, b0, 1'b1);
    applyStimulus(1'b0, 1'b1, a1, b1, 1'b1);
    checkOutput({tag, "_reduce_no_valid"}, 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_out_hv"}, 32'(out_hv), 32'(expected));
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nrst           = 1'b1;
    start_encoding = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b1;
    shifted_hv[0]  = 16'h0;
    shifted_hv[1]  = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready",  32'(in_ready),  32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_hv",    32'(out_hv),    32'd0);
    checkOutput("reset_busy",      32'(busy),      32'd0);
    nrst = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);

    $display("[TB] basic vote");
    runSample("basic", 16'h000F, 16'h00FF, 16'h0F0F, 16'h0000, EXP_BASIC);

    $display("[TB] backpressure and gating");
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'hF0F0, 16'hFF00, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0F00, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i == 3, i == 5, 16'hFFFF, 16'hFFFF, 1'b0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
      checkOutput("bp_out_hv",    32'(out_hv),    32'(EXP_GATE));
    end
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_idle",  32'(busy),      32'd0);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    checkOutput("idle_gate_in_ready", 32'(in_ready), 32'd0);
    checkOutput("idle_gate_busy",     32'(busy),     32'd0);
    runSample("after_gate", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    $display("[TB] restart");
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput("restart_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput("restart_out_valid", 32'(out_valid), 32'd1);
    checkOutput("restart_out_hv",    32'(out_hv),    32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);

    $display("[TB] restart with same-cycle beat");
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h000F, 16'h00FF, 1'b1);
    checkOutput("restart_beat_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h0F0F, 16'h0000, 1'b1);
    checkOutput("restart_beat_reduce", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput("restart_beat_out_valid", 32'(out_valid), 32'd1);
    checkOutput("restart_beat_out_hv",    32'(out_hv),    32'(EXP_BASIC));
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);

    $display("[TB] async reset mid-accumulation");
    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    #3;
    nrst = 1'b1;
    #1;
    checkOutput("areset_busy",      32'(busy),      32'd0);
    checkOutput("areset_in_ready",  32'(in_ready),  32'd0);
    checkOutput("areset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("areset_out_hv",    32'(out_hv),    32'd0);
    #1;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    runSample("post_reset", 16'h000F, 16'h00FF, 16'h0F0F, 16'h0000, EXP_BASIC);

`ifdef ENC_BUNDLER_SEG_SPARSIFY_EN
    $display("[TB] sparsify");
    runSample("sparse_tie",  16'h0024, 16'h0000, 16'h0000, 16'h0024, 16'h0004);
    runSample("sparse_max",  16'h0024, 16'h3000, 16'h0020, 16'h1000, 16'h1020);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
